// File: rtl/lin_comb_seq_arbiter.sv
// Two-client arbiter + shift-add sequencer for F = COEF_A*X - COEF_B*Y; result 2*W_IN edges after capture, held until i_ready.
// Requests are ignored while busy; `LINCOMB_RR_EN selects round-robin tie-breaking instead of fixed ch0 priority.
module lin_comb_seq_arbiter #(
  parameter int unsigned COEF_A = 6,
  parameter int unsigned COEF_B = 11,
  parameter int unsigned W_IN   = 4,
  parameter int unsigned W_OUT  = 9
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_req0,
  input  logic                    i_req1,
  input  logic [W_IN-1:0]         i_x0,
  input  logic [W_IN-1:0]         i_y0,
  input  logic [W_IN-1:0]         i_x1,
  input  logic [W_IN-1:0]         i_y1,
  output logic                    o_gnt0,
  output logic                    o_gnt1,
  output logic                    o_busy,
  output logic                    o_valid,
  output logic                    o_id,
  output logic signed [W_OUT-1:0] o_f,
  input  logic                    i_ready
);

  localparam int unsigned CW = (W_IN > 1) ? $clog2(W_IN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(W_IN - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL_X, S_MUL_Y, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic signed [W_OUT-1:0] acc_q, acc_d;
  logic [W_IN-1:0]         x_q, x_d, y_q, y_d;
  logic                    id_q, id_d;
  logic signed [W_OUT-1:0] f_q, f_d;
  logic                    oid_q, oid_d;
  logic                    valid_q, valid_d;
  logic                    gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic                    win1;
  logic signed [W_OUT-1:0] term_a, term_b;

`ifdef LINCOMB_RR_EN
  logic ptr_q, ptr_d;
  // On a tie the channel that did not win last time gets the grant.
  assign win1 = i_req1 && (!i_req0 || !ptr_q);
`else
  assign win1 = i_req1 && !i_req0;
`endif

  assign term_a = W_OUT'(COEF_A) << cnt_q;
  assign term_b = W_OUT'(COEF_B) << cnt_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    x_d     = x_q;
    y_d     = y_q;
    id_d    = id_q;
    f_d     = f_q;
    oid_d   = oid_q;
    valid_d = valid_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
`ifdef LINCOMB_RR_EN
    ptr_d   = ptr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (i_req0 || i_req1) begin
          id_d    = win1;
          x_d     = win1 ? i_x1 : i_x0;
          y_d     = win1 ? i_y1 : i_y0;
          acc_d   = '0;
          cnt_d   = '0;
          gnt0_d  = !win1;
          gnt1_d  = win1;
          state_d = S_MUL_X;
`ifdef LINCOMB_RR_EN
          ptr_d   = win1;
`endif
        end
      end
      S_MUL_X: begin
        if (x_q[cnt_q]) acc_d = acc_q + term_a;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_MUL_Y;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_MUL_Y: begin
        if (y_q[cnt_q]) acc_d = acc_q - term_b;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          f_d     = acc_d;
          oid_d   = id_q;
          valid_d = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        if (i_ready) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      id_q    <= 1'b0;
      f_q     <= '0;
      oid_q   <= 1'b0;
      valid_q <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
`ifdef LINCOMB_RR_EN
      ptr_q   <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      x_q     <= x_d;
      y_q     <= y_d;
      id_q    <= id_d;
      f_q     <= f_d;
      oid_q   <= oid_d;
      valid_q <= valid_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
`ifdef LINCOMB_RR_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign o_gnt0  = gnt0_q;
  assign o_gnt1  = gnt1_q;
  assign o_busy  = (state_q != S_IDLE);
  assign o_valid = valid_q;
  assign o_id    = oid_q;
  assign o_f     = f_q;

endmodule

// File: tb/tb_lin_comb_seq_arbiter.sv
// Directed bench for lin_comb_seq_arbiter: latency, arithmetic, arbitration, backpressure and mid-op reset.
module tb_lin_comb_seq_arbiter;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_req0, i_req1;
  logic [3:0] i_x0, i_y0, i_x1, i_y1;
  logic       o_gnt0, o_gnt1, o_busy, o_valid, o_id;
  logic [8:0] o_f;
  logic       i_ready;

  int n_checks = 0;
  int n_fail   = 0;

  lin_comb_seq_arbiter dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_req0  (i_req0),
    .i_req1  (i_req1),
    .i_x0    (i_x0),
    .i_y0    (i_y0),
    .i_x1    (i_x1),
    .i_y1    (i_y1),
    .o_gnt0  (o_gnt0),
    .o_gnt1  (o_gnt1),
    .o_busy  (o_busy),
    .o_valid (o_valid),
    .o_id    (o_id),
    .o_f     (o_f),
    .i_ready (i_ready)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete operation with i_ready high: capture, 8-edge latency, handshake.
  task automatic run_op(input logic ch, input logic [3:0] x, input logic [3:0] y,
                        input logic [8:0] exp_f);
    if (ch) begin i_req1 = 1'b1; i_x1 = x; i_y1 = y; end
    else    begin i_req0 = 1'b1; i_x0 = x; i_y0 = y; end
    tick();
    check("gnt_winner", ch ? o_gnt1 : o_gnt0, 1);
    check("gnt_other",  ch ? o_gnt0 : o_gnt1, 0);
    check("busy_after_capture", o_busy, 1);
    i_req0 = 1'b0;
    i_req1 = 1'b0;
    repeat (7) tick();
    check("valid_early", o_valid, 0);
    tick();
    check("valid_rise", o_valid, 1);
    check("result_f", o_f, exp_f);
    check("result_id", o_id, ch);
    tick();
    check("valid_after_hs", o_valid, 0);
    check("busy_after_hs", o_busy, 0);
  endtask

  initial begin
    logic [3:0] xv, yv;
    int         e;
    logic       exp_id;

    i_rst = 1'b1; i_req0 = 1'b0; i_req1 = 1'b0; i_ready = 1'b1;
    i_x0 = '0; i_y0 = '0; i_x1 = '0; i_y1 = '0;
    tick(); tick();
    check("rst_gnt0", o_gnt0, 0);
    check("rst_gnt1", o_gnt1, 0);
    check("rst_busy", o_busy, 0);
    check("rst_valid", o_valid, 0);
    check("rst_id", o_id, 0);
    check("rst_f", o_f, 0);
    i_rst = 1'b0;
    tick();
    check("idle_no_req_busy", o_busy, 0);

    run_op(1'b0, 4'd15, 4'd0,  9'h05A);
    run_op(1'b0, 4'd0,  4'd15, 9'h15B);
    run_op(1'b0, 4'd15, 4'd15, 9'h1B5);

    for (int i = 0; i < 256; i++) begin
      xv = 4'(i >> 4);
      yv = 4'(i);
      e  = 6 * int'(xv) - 11 * int'(yv);
      run_op(i[0], xv, yv, 9'(e));
    end

    // Tie: both requests held continuously.
    i_rst = 1'b1; tick(); i_rst = 1'b0;
    i_req0 = 1'b1; i_x0 = 4'd1; i_y0 = 4'd0;
    i_req1 = 1'b1; i_x1 = 4'd0; i_y1 = 4'd1;
    for (int k = 0; k < 4; k++) begin
`ifdef LINCOMB_RR_EN
      exp_id = k[0];
`else
      exp_id = 1'b0;
`endif
      tick();
      check("tie_gnt1", o_gnt1, exp_id);
      repeat (8) tick();
      check("tie_valid", o_valid, 1);
      check("tie_id", o_id, exp_id);
      check("tie_f", o_f, exp_id ? 9'h1F5 : 9'h006);
      tick();
    end
    i_req0 = 1'b0; i_req1 = 1'b0;
    tick();

    // Backpressure with ch1 waiting.
    i_rst = 1'b1; tick(); i_rst = 1'b0;
    i_ready = 1'b0;
    i_req0 = 1'b1; i_x0 = 4'd2; i_y0 = 4'd1;
    tick();
    i_req0 = 1'b0;
    repeat (8) tick();
    check("bp_valid", o_valid, 1);
    i_req1 = 1'b1; i_x1 = 4'd3; i_y1 = 4'd1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_hold_valid", o_valid, 1);
      check("bp_hold_f", o_f, 9'h001);
      check("bp_hold_id", o_id, 0);
      check("bp_no_gnt1", o_gnt1, 0);
      check("bp_busy", o_busy, 1);
    end
    i_ready = 1'b1;
    tick();
    check("bp_hs_valid", o_valid, 0);
    check("bp_hs_busy", o_busy, 0);
    tick();
    check("bp_capture_gnt1", o_gnt1, 1);
    i_req1 = 1'b0;
    repeat (8) tick();
    check("bp_next_valid", o_valid, 1);
    check("bp_next_f", o_f, 9'h007);
    check("bp_next_id", o_id, 1);
    tick();

    // Reset during the second MUL_Y cycle.
    i_req0 = 1'b1; i_x0 = 4'd15; i_y0 = 4'd15;
    tick();
    i_req0 = 1'b0;
    repeat (5) tick();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    check("mr_gnt0", o_gnt0, 0);
    check("mr_gnt1", o_gnt1, 0);
    check("mr_busy", o_busy, 0);
    check("mr_valid", o_valid, 0);
    check("mr_id", o_id, 0);
    check("mr_f", o_f, 0);
    repeat (6) tick();
    check("mr_no_valid", o_valid, 0);
    check("mr_still_idle", o_busy, 0);
    run_op(1'b1, 4'd3, 4'd1, 9'h007);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
